// File: rtl/axi_slave_mem_resp_pkg.sv
// Shared definitions for the AXI4 memory responder: FSM state encodings,
// AXI burst/response encodings and the line-size helpers.
package axi_slave_mem_resp_pkg;

  typedef logic [1:0] w_state_t;
  typedef logic [0:0] r_state_t;

  localparam w_state_t W_IDLE = 2'd0;
  localparam w_state_t W_DATA = 2'd1;
  localparam w_state_t W_RESP = 2'd2;

  localparam r_state_t R_IDLE = 1'b0;
  localparam r_state_t R_DATA = 1'b1;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Byte-offset width of one memory line (log2 of bytes per line).
  function automatic int calc_lb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  // Only incrementing bursts map onto consecutive lines of the array.
  function automatic logic burst_is_valid(input logic [1:0] burst);
    case (burst)
      BURST_INCR:              return 1'b1;
      BURST_FIXED, BURST_WRAP: return 1'b0;
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/axi_slave_mem_array.sv
// Dual-port byte-enabled line memory. One write port, one registered read
// port; a read and write to the same line in one cycle returns the old data.
module axi_slave_mem_array #(
  parameter int DATA_WIDTH = 1024,
  parameter int DEPTH_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    re,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int DEPTH  = 1 << DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Byte-masked write and read-first registered read share one edge.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axi_slave_mem_resp.sv
// AXI4 responder backed by an internal line array. Independent write
// (AW/W/B) and read (AR/R) state machines, one outstanding burst each,
// with burst and error counters.
module axi_slave_mem_resp
  import axi_slave_mem_resp_pkg::*;
#(
  parameter int ID_WIDTH       = 2,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 1024,
  parameter int MEM_DEPTH_LOG2 = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [31:0]             wr_burst_cnt,
  output logic [31:0]             rd_burst_cnt,
  output logic [15:0]             err_cnt
);

  localparam int         LB        = calc_lb(DATA_WIDTH);
  localparam int         DL        = MEM_DEPTH_LOG2;
  localparam logic [2:0] SIZE_LINE = 3'(LB);

  function automatic logic [31:0] sat_inc32(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + {15'd0, inc};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  // Only the line-index bits of the addresses matter to this memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

  // ---------------- write side ----------------
  w_state_t            w_state;
  logic [ID_WIDTH-1:0] wr_id;
  logic [7:0]          wr_len;
  logic [7:0]          wr_beat;
  logic [DL-1:0]       wr_idx;
  logic                wr_err;
  logic [1:0]          wr_resp;
  logic                w_beat_err;
  logic                w_fire;
  logic                b_fire;
  logic                mem_we;

  // A beat is bad if the burst is already bad or wlast disagrees with the beat count.
  assign w_beat_err = wr_err | (s_axi_wlast != (wr_beat == wr_len));
  assign w_fire     = (w_state == W_DATA) && s_axi_wvalid;
  assign b_fire     = (w_state == W_RESP) && s_axi_bready;
  assign mem_we     = w_fire && !w_beat_err;

  assign s_axi_awready = (w_state == W_IDLE);
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_RESP);
  assign s_axi_bid     = wr_id;
  assign s_axi_bresp   = wr_resp;

  // Write FSM: capture AW, walk the W beats, hold B until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      wr_id   <= '0;
      wr_len  <= '0;
      wr_beat <= '0;
      wr_idx  <= '0;
      wr_err  <= 1'b0;
      wr_resp <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (s_axi_awvalid) begin
            wr_id   <= s_axi_awid;
            wr_len  <= s_axi_awlen;
            wr_beat <= '0;
            wr_idx  <= s_axi_awaddr[LB +: DL];
            wr_err  <= !burst_is_valid(s_axi_awburst) || (s_axi_awsize != SIZE_LINE);
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid) begin
            wr_err  <= w_beat_err;
            wr_beat <= wr_beat + 8'd1;
            wr_idx  <= wr_idx + 1'b1;
            if (s_axi_wlast) begin
              wr_resp <= w_beat_err ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s_axi_bready) begin
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------- read side ----------------
  r_state_t              r_state;
  logic [ID_WIDTH-1:0]   rd_id;
  logic [7:0]            rd_len;
  logic [7:0]            rd_beat;
  logic [DL-1:0]         rd_idx;
  logic                  rd_err;
  logic [1:0]            rd_resp;
  logic                  ar_fire;
  logic                  r_fire;
  logic                  rd_last;
  logic                  r_done;
  logic                  mem_re;
  logic [DL-1:0]         mem_raddr;
  logic [DATA_WIDTH-1:0] mem_rdata;

  assign ar_fire = (r_state == R_IDLE) && s_axi_arvalid;
  assign r_fire  = (r_state == R_DATA) && s_axi_rready;
  assign rd_last = (rd_beat == rd_len);
  assign r_done  = r_fire && rd_last;

  // The array read is only issued when a new beat is due, so the array
  // output register holds rdata steady through rready stalls.
  assign mem_re    = ar_fire || (r_fire && !rd_last);
  assign mem_raddr = (r_state == R_IDLE) ? s_axi_araddr[LB +: DL] : rd_idx + 1'b1;

  assign s_axi_arready = (r_state == R_IDLE);
  assign s_axi_rvalid  = (r_state == R_DATA);
  assign s_axi_rlast   = (r_state == R_DATA) && rd_last;
  assign s_axi_rid     = rd_id;
  assign s_axi_rresp   = rd_resp;
  assign s_axi_rdata   = ((r_state == R_DATA) && !rd_err) ? mem_rdata : '0;

  // Read FSM: capture AR, then present arlen+1 beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      rd_id   <= '0;
      rd_len  <= '0;
      rd_beat <= '0;
      rd_idx  <= '0;
      rd_err  <= 1'b0;
      rd_resp <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (s_axi_arvalid) begin
            rd_id   <= s_axi_arid;
            rd_len  <= s_axi_arlen;
            rd_beat <= '0;
            rd_idx  <= s_axi_araddr[LB +: DL];
            rd_err  <= !burst_is_valid(s_axi_arburst) || (s_axi_arsize != SIZE_LINE);
            rd_resp <= (!burst_is_valid(s_axi_arburst) || (s_axi_arsize != SIZE_LINE))
                       ? RESP_SLVERR : RESP_OKAY;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (s_axi_rready) begin
            if (rd_last) begin
              r_state <= R_IDLE;
            end else begin
              rd_beat <= rd_beat + 8'd1;
              rd_idx  <= rd_idx + 1'b1;
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  axi_slave_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH_LOG2 (DL)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_idx),
    .wdata (s_axi_wdata),
    .wstrb (s_axi_wstrb),
    .re    (mem_re),
    .raddr (mem_raddr),
    .rdata (mem_rdata)
  );

  // ---------------- counters ----------------
  logic [1:0] err_inc;
  assign err_inc = {1'b0, b_fire && (wr_resp == RESP_SLVERR)} + {1'b0, r_done && rd_err};

  // Saturating burst and error counters; a write and read error can land together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
      err_cnt      <= '0;
    end else begin
      if (b_fire) wr_burst_cnt <= sat_inc32(wr_burst_cnt);
      if (r_done) rd_burst_cnt <= sat_inc32(rd_burst_cnt);
      err_cnt <= sat_add16(err_cnt, err_inc);
    end
  end

endmodule
